sd_sacq_decoder: RTL and testbench

Sequence decoder at the receiving end of the 11-bit acquisition event word driven by the acquisition coder (the `i` bus). It samples the word on `clk_sys` and rejects glitches with a stability filter. It then edge-detects the seven one-hot event bits and steps a state machine that drives the receiver protection switch, the acquisition gate, and the channel and phase flags used by the sampling logic. It also counts acquisition windows per sequence.

---
 rtl/sd_sacq_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_sd_sacq_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sacq_decoder.sv
`default_nettype none
// ============================================================================
// Module  : sd_sacq_decoder
// Brief   : Acquisition event-word decoder: sync + stability filter, one-hot
//           event edge detection and a sequence FSM driving switch/gate flags.
// Revision: 1.0 - initial release
// ============================================================================
module sd_sacq_decoder #(
    parameter int FILT_LEN = 2,
    parameter int ECHO_MAX = 1023
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [10:0] code_in,
    input  logic        code_en,
    output logic        sw_open,
    output logic        acq_gate,
    output logic        ch_sel,
    output logic        acq_phase,
    output logic [9:0]  echo_cnt,
    output logic        seq_done,
    output logic        code_err
);

    localparam logic [2:0] c_FILT_TGT = 3'(FILT_LEN - 1);
    localparam logic [2:0] c_STAB_MAX = 3'd7;
    localparam logic [9:0] c_ECHO_MAX = 10'(ECHO_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_OPEN  = 3'd2,
        S_ACQ   = 3'd3,
        S_LONG  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and stability filter
    // ------------------------------------------------------------------
    logic [10:0] r_code_s1;
    logic [10:0] r_code_s2;
    logic [2:0]  r_stab;
    logic [10:0] r_code_f;
    logic        r_f0_d;
    logic [6:0]  r_ev_d;
    logic        r_f_upd;

    logic [2:0]  w_stab_nxt;
    logic        w_f_load;

    // The counter tracks the value about to enter code_s2, so code_f can
    // take it on the same edge the required run length is reached.
    always_comb begin
        w_stab_nxt = 3'd0;
        if (r_code_s1 == r_code_s2) begin
            w_stab_nxt = (r_stab == c_STAB_MAX) ? c_STAB_MAX : r_stab + 3'd1;
        end
        w_f_load = (w_stab_nxt == c_FILT_TGT);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_code_s1 <= 11'd0;
            r_code_s2 <= 11'd0;
            r_stab    <= 3'd0;
            r_code_f  <= 11'd0;
            r_f0_d    <= 1'b0;
            r_ev_d    <= 7'd0;
            r_f_upd   <= 1'b0;
        end else begin
            r_code_s1 <= code_in;
            r_code_s2 <= r_code_s1;
            r_stab    <= w_stab_nxt;
            if (w_f_load) begin
                r_code_f <= r_code_s1;
            end
            r_f0_d    <= r_code_f[0];
            r_ev_d    <= r_code_f[10:4];
            r_f_upd   <= w_f_load && (r_code_s1 != r_code_f);
        end
    end

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic       w_rise0;
    logic       w_fall0;
    logic       w_ev_ok;
    logic [6:0] w_ev;

    always_comb begin
        w_rise0 = r_code_f[0] & ~r_f0_d;
        w_fall0 = ~r_code_f[0] & r_f0_d;
        w_ev_ok = ((r_code_f[10:4] & (r_code_f[10:4] - 7'd1)) == 7'd0);
        w_ev    = w_ev_ok ? (r_code_f[10:4] & ~r_ev_d) : 7'd0;
    end

    // ------------------------------------------------------------------
    // Sequence FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    logic       r_sw_open;
    logic       r_acq_gate;
    logic       r_ch_sel;
    logic       r_acq_phase;
    logic [9:0] r_echo_cnt;
    logic       r_seq_done;
    logic       r_code_err;

    state_t     w_state_nxt;
    logic       w_sw_nxt;
    logic       w_gate_nxt;
    logic       w_ch_nxt;
    logic       w_phase_nxt;
    logic [9:0] w_echo_nxt;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic [9:0] w_echo_inc;

    always_comb begin
        w_echo_inc  = (r_echo_cnt == c_ECHO_MAX) ? r_echo_cnt : r_echo_cnt + 10'd1;
        w_state_nxt = r_state;
        w_sw_nxt    = r_sw_open;
        w_gate_nxt  = r_acq_gate;
        w_ch_nxt    = r_ch_sel;
        w_phase_nxt = r_acq_phase;
        w_echo_nxt  = r_echo_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_f_upd & ~w_ev_ok;

        if (!code_en) begin
            w_state_nxt = S_IDLE;
            w_sw_nxt    = 1'b0;
            w_gate_nxt  = 1'b0;
            w_ch_nxt    = 1'b0;
            w_phase_nxt = 1'b0;
        end else if ((r_state != S_IDLE) && w_fall0) begin
            w_state_nxt = S_IDLE;
            w_sw_nxt    = 1'b0;
            w_gate_nxt  = 1'b0;
            w_ch_nxt    = 1'b0;
            w_phase_nxt = 1'b0;
            w_done_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sw_nxt    = 1'b0;
                    w_gate_nxt  = 1'b0;
                    w_ch_nxt    = 1'b0;
                    w_phase_nxt = 1'b0;
                    if (w_rise0) begin
                        w_state_nxt = S_ARMED;
                        w_ch_nxt    = r_code_f[1];
                        w_echo_nxt  = 10'd0;
                    end
                end
                S_ARMED: begin
                    if (w_ev[0]) begin
                        w_state_nxt = S_OPEN;
                        w_sw_nxt    = 1'b1;
                    end else if (w_ev[3]) begin
                        w_state_nxt = S_LONG;
                        w_sw_nxt    = 1'b1;
                    end
                end
                S_OPEN: begin
                    if (w_ev[1]) begin
                        w_state_nxt = S_ACQ;
                        w_gate_nxt  = 1'b1;
                        w_phase_nxt = r_code_f[2];
                        w_echo_nxt  = w_echo_inc;
                    end
                end
                S_ACQ: begin
                    if (w_ev[2]) begin
                        w_gate_nxt = 1'b0;
                        if (r_code_f[3]) begin
                            w_state_nxt = S_LONG;
                        end else begin
                            w_state_nxt = S_ARMED;
                            w_sw_nxt    = 1'b0;
                        end
                    end
                end
                S_LONG: begin
                    if (w_ev[4]) begin
                        w_state_nxt = S_ARMED;
                        w_sw_nxt    = 1'b0;
                        w_gate_nxt  = 1'b0;
                    end else if (w_ev[5]) begin
                        w_gate_nxt = 1'b1;
                        w_echo_nxt = w_echo_inc;
                    end else if (w_ev[6]) begin
                        w_gate_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_sw_nxt    = 1'b0;
                    w_gate_nxt  = 1'b0;
                    w_ch_nxt    = 1'b0;
                    w_phase_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sw_open   <= 1'b0;
            r_acq_gate  <= 1'b0;
            r_ch_sel    <= 1'b0;
            r_acq_phase <= 1'b0;
            r_echo_cnt  <= 10'd0;
            r_seq_done  <= 1'b0;
            r_code_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sw_open   <= w_sw_nxt;
            r_acq_gate  <= w_gate_nxt;
            r_ch_sel    <= w_ch_nxt;
            r_acq_phase <= w_phase_nxt;
            r_echo_cnt  <= w_echo_nxt;
            r_seq_done  <= w_done_nxt;
            r_code_err  <= w_err_nxt;
        end
    end

    assign sw_open   = r_sw_open;
    assign acq_gate  = r_acq_gate;
    assign ch_sel    = r_ch_sel;
    assign acq_phase = r_acq_phase;
    assign echo_cnt  = r_echo_cnt;
    assign seq_done  = r_seq_done;
    assign code_err  = r_code_err;

endmodule
`default_nettype wire

// File: tb/tb_sd_sacq_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_sacq_decoder
// Brief   : Directed self-checking bench for sd_sacq_decoder (FILT_LEN=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sd_sacq_decoder;

    logic        clk_sys;
    logic        rst_n;
    logic [10:0] code_in;
    logic        code_en;
    logic        sw_open;
    logic        acq_gate;
    logic        ch_sel;
    logic        acq_phase;
    logic [9:0]  echo_cnt;
    logic        seq_done;
    logic        code_err;

    int n_tests;
    int n_fail;
    logic r_seen;

    sd_sacq_decoder #(
        .FILT_LEN (2),
        .ECHO_MAX (1023)
    ) u_dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .code_en   (code_en),
        .sw_open   (sw_open),
        .acq_gate  (acq_gate),
        .ch_sel    (ch_sel),
        .acq_phase (acq_phase),
        .echo_cnt  (echo_cnt),
        .seq_done  (seq_done),
        .code_err  (code_err)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        code_in = 11'h000;
        code_en = 1'b1;
        tick(3);
        check("rst_sw",    32'(sw_open),   0);
        check("rst_gate",  32'(acq_gate),  0);
        check("rst_ch",    32'(ch_sel),    0);
        check("rst_phase", 32'(acq_phase), 0);
        check("rst_echo",  32'(echo_cnt),  0);
        check("rst_done",  32'(seq_done),  0);
        check("rst_err",   32'(code_err),  0);
        rst_n = 1'b1;
        tick(2);

        // Sequence start -> ARMED
        code_in = 11'h001;
        tick(5);
        check("armed_sw", 32'(sw_open), 0);

        // ev1 -> OPEN, with latency check
        code_in = 11'h011;
        tick(3);
        check("open_sw_lat", 32'(sw_open), 0);
        tick(1);
        check("open_sw", 32'(sw_open), 1);
        tick(1);

        // ev2 with s_acq180 -> ACQ
        code_in = 11'h025;
        tick(3);
        check("acq_gate_lat", 32'(acq_gate), 0);
        tick(1);
        check("acq_gate",  32'(acq_gate),  1);
        check("acq_phase", 32'(acq_phase), 1);
        check("acq_echo",  32'(echo_cnt),  1);
        check("acq_sw",    32'(sw_open),   1);
        tick(1);

        // ev3 with long_opentime -> LONG
        code_in = 11'h049;
        tick(4);
        check("long_gate", 32'(acq_gate), 0);
        check("long_sw",   32'(sw_open),  1);
        tick(1);

        code_in = 11'h209;
        tick(4);
        check("ev6_gate", 32'(acq_gate), 1);
        check("ev6_echo", 32'(echo_cnt), 2);
        tick(1);

        code_in = 11'h409;
        tick(4);
        check("ev7_gate", 32'(acq_gate), 0);
        check("ev7_echo", 32'(echo_cnt), 2);
        tick(1);

        code_in = 11'h109;
        tick(4);
        check("ev5_sw",   32'(sw_open),  0);
        check("ev5_gate", 32'(acq_gate), 0);
        tick(1);

        // One-cycle glitch while ARMED must be filtered out
        code_in = 11'h001;
        tick(5);
        code_in = 11'h011;
        tick(1);
        code_in = 11'h001;
        tick(6);
        check("glitch_sw",  32'(sw_open),  0);
        check("glitch_err", 32'(code_err), 0);

        // Still ARMED: a real ev1 opens the switch
        code_in = 11'h011;
        tick(4);
        check("rearm_sw", 32'(sw_open), 1);
        tick(1);

        // Multi-hot event field in OPEN: one error pulse, ev2 ignored
        code_in = 11'h031;
        tick(3);
        check("err_lat", 32'(code_err), 0);
        tick(1);
        check("err_pulse",   32'(code_err), 1);
        check("err_no_gate", 32'(acq_gate), 0);
        tick(1);
        check("err_width", 32'(code_err), 0);
        code_in = 11'h011;
        tick(5);
        check("err_hold_gate", 32'(acq_gate), 0);
        check("err_hold_sw",   32'(sw_open),  1);

        // Back into ACQ, then abort with fall of state_start
        code_in = 11'h025;
        tick(4);
        check("acq2_gate", 32'(acq_gate), 1);
        check("acq2_echo", 32'(echo_cnt), 3);
        tick(1);
        code_in = 11'h000;
        tick(3);
        check("done_lat", 32'(seq_done), 0);
        tick(1);
        check("done_pulse", 32'(seq_done),  1);
        check("done_sw",    32'(sw_open),   0);
        check("done_gate",  32'(acq_gate),  0);
        check("done_phase", 32'(acq_phase), 0);
        check("done_echo",  32'(echo_cnt),  3);
        tick(1);
        check("done_width", 32'(seq_done), 0);
        check("idle_echo",  32'(echo_cnt), 3);
        tick(3);

        // New sequence with bb_ch=1; then disable
        code_in = 11'h003;
        tick(4);
        check("start_ch",   32'(ch_sel),   1);
        check("start_echo", 32'(echo_cnt), 0);
        tick(1);
        code_in = 11'h013;
        tick(4);
        check("en_sw_pre", 32'(sw_open), 1);
        code_en = 1'b0;
        tick(1);
        check("dis_sw",   32'(sw_open),  0);
        check("dis_ch",   32'(ch_sel),   0);
        check("dis_done", 32'(seq_done), 0);
        code_en = 1'b1;
        code_in = 11'h000;
        r_seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            r_seen = r_seen | seq_done;
        end
        check("dis_no_done", 32'(r_seen), 0);

        // Asynchronous reset while LONG
        code_in = 11'h001;
        tick(5);
        code_in = 11'h081;
        tick(4);
        check("ev4_sw", 32'(sw_open), 1);
        rst_n = 1'b0;
        #1;
        check("arst_sw",   32'(sw_open),  0);
        check("arst_ch",   32'(ch_sel),   0);
        check("arst_echo", 32'(echo_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_sw", 32'(sw_open), 0);

        // Already-high state_start re-arms; count windows to saturation
        for (int i = 0; i < 1024; i++) begin
            code_in = 11'h011;
            tick(4);
            code_in = 11'h021;
            tick(4);
            code_in = 11'h041;
            tick(4);
            if (i == 0) check("sat_first", 32'(echo_cnt), 1);
            if (i == 1022) check("sat_1023", 32'(echo_cnt), 1023);
        end
        check("sat_hold", 32'(echo_cnt), 1023);
        check("sat_sw",   32'(sw_open),  0);
        check("sat_gate", 32'(acq_gate), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
